systolic_os_array: RTL and testbench
====================================

Name: systolic_os_array

Overview:
- Parametrised output-stationary successor to the weight-streaming systolic array: computes C = A×B for an ROWS×K by K×COLS signed matrix pair.
- Each PE owns one C element and accumulates in place.
- Input skewing, valid tagging, flush timing and result drain are built in, so the upstream loader streams unskewed columns of A and rows of B under a ready/valid handshake.
- Sits between the operand buffers and the writeback/activation stage.

Parameters:
- DATA_WIDTH, 16, operand width (signed two's complement).
- ACC_WIDTH, 40, per-PE accumulator width (signed).
- OUT_WIDTH, 16, result width after saturation.
- ROWS, 4, PE rows (≥1).
- COLS, 4, PE columns (≥1).
- K_WIDTH, 16, width of the inner-dimension length field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start_i  in  1  begin a job; sampled only in IDLE.
- k_len_i  in  K_WIDTH  inner dimension K; sampled with start_i.
- clear_i  in  1  synchronous abort.
- in_valid_i  in  1  operand beat valid.
- in_ready_o  out  1  operand beat accepted when valid&ready.
- a_i  in  ROWS×DATA_WIDTH  beat k: a_i[r] = A[r][k].
- b_i  in  COLS×DATA_WIDTH  beat k: b_i[c] = B[k][c].
- out_valid_o  out  1  result row valid.
- out_ready_i  in  1  downstream accepts row.
- out_row_o  out  clog2(ROWS) (min 1)  index of presented row.
- out_data_o  out  COLS×OUT_WIDTH  C[out_row_o][0..COLS-1], saturated.
- busy_o  out  1  state ≠ IDLE.
- done_o  out  1  one-cycle pulse when a job completes.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all accumulators, skew registers and valid tags cleared. Outputs in_ready_o, out_valid_o, busy_o and done_o are 0; out_row_o is 0; out_data_o is 0. Reset mid-job abandons the job with no done_o.
- FSM: IDLE → STREAM → FLUSH → DRAIN → IDLE.
- IDLE:
  - start_i=1 with k_len_i>0: latch K, clear beat counter, go to STREAM.
  - start_i=1 with k_len_i=0: stay IDLE; done_o pulses on the next cycle; no output rows.
- STREAM:
  - in_ready_o=1.
  - Each accepted beat increments the beat counter. The beat entering on the cycle the counter reaches K moves the FSM to FLUSH.
  - Cycles with in_valid_i=0 are bubbles: the zero-valid tag propagates through the array and no PE accumulates on it.
- Skew:
  - Row r's operand passes through r register stages before PE(r,0); column c's operand passes through c stages before PE(0,c).
  - A moves right and B moves down one PE per cycle, each carrying a valid tag.
  - PE(r,c) does acc += a×b (full-precision product, sign-extended to ACC_WIDTH, wrapping add) only when the arriving tag is 1.
- FLUSH: fixed (ROWS-1)+(COLS-1)+1 cycles counted from the cycle after the last accepted beat; in_ready_o=0. Then go to DRAIN with row index 0.
- DRAIN:
  - out_valid_o=1, out_row_o=i, out_data_o[c] = sat(acc[i][c]).
  - sat clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Outputs are held stable while out_ready_i=0.
  - On valid&ready, i increments. On acceptance of row ROWS-1: all accumulators and tags are cleared, done_o=1 for that next cycle, state goes to IDLE.
- start_i outside IDLE is ignored.
- clear_i=1 in any state: next state IDLE, accumulators and tags cleared, no done_o. clear_i has priority over start_i and over every handshake in the same cycle.
- Throughput: one beat per cycle in STREAM; one row per cycle in DRAIN under continuous out_ready_i.

Test Plan:
- ROWS=COLS=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], streamed back-to-back, out_ready_i=1 → row0=(19,22), row1=(43,50); done_o pulses once; busy_o low afterwards.
- Same operands with in_valid_i toggled 1,0,0,1 → identical results; FLUSH starts only after the 2nd accepted beat.
- Signed/saturation, K=2: a=32767, b=32767 on every beat → every output 32767. With a=-32768, b=32767 → every output -32768.
- Backpressure: out_ready_i held 0 for 5 cycles in DRAIN → out_row_o=0 and out_data_o stable; no done_o until both rows are accepted.
- Abort: clear_i pulsed mid-STREAM after 1 beat, then a new K=1 job with a=(2,3), b=(4,5) → rows (8,10),(12,15); no residue from the aborted job.
- start_i with k_len_i=0 → done_o pulses next cycle; out_valid_o never asserts. Also: rst_n=0 during DRAIN → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/systolic_os_array.sv
`default_nettype none
// =====================================================================
// systolic_os_array : output-stationary signed GEMM array with built-in
// operand skew, valid tagging, flush timing and saturated row drain.
// Rev 1.0
// =====================================================================
module systolic_os_array #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 16,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int K_WIDTH    = 16,
    localparam int C_RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [K_WIDTH-1:0]          k_len_i,
    input  logic                        clear_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [ROWS*DATA_WIDTH-1:0]  a_i,
    input  logic [COLS*DATA_WIDTH-1:0]  b_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [C_RW-1:0]             out_row_o,
    output logic [COLS*OUT_WIDTH-1:0]   out_data_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int C_FLUSH = ROWS + COLS - 1;
    localparam int C_FW    = $clog2(C_FLUSH + 1);
    localparam logic [C_FW-1:0] C_FLUSH_LAST = C_FW'(C_FLUSH - 1);
    localparam logic [C_RW-1:0] C_ROW_LAST   = C_RW'(ROWS - 1);
    localparam logic signed [ACC_WIDTH-1:0] C_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] C_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t              state_q;
    logic [K_WIDTH-1:0]  k_q;
    logic [K_WIDTH-1:0]  cnt_q;
    logic [C_FW-1:0]     fcnt_q;
    logic [C_RW-1:0]     row_q;
    logic                ready_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;

    logic                w_beat;
    logic                w_last_accept;
    logic                w_clr;

    logic [DATA_WIDTH-1:0] w_a_in  [ROWS][COLS];
    logic                  w_av_in [ROWS][COLS];
    logic [DATA_WIDTH-1:0] w_b_in  [ROWS][COLS];
    logic                  w_bv_in [ROWS][COLS];
    logic [OUT_WIDTH-1:0]  w_sat   [ROWS][COLS];

    assign w_beat        = (state_q == S_STREAM) && in_valid_i;
    assign w_last_accept = (state_q == S_DRAIN) && out_ready_i && (row_q == C_ROW_LAST);
    assign w_clr         = !rst_n || clear_i || w_last_accept;

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            row_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (k_len_i != '0) begin
                            state_q <= S_STREAM;
                            k_q     <= k_len_i;
                            cnt_q   <= '0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (in_valid_i) begin
                        cnt_q <= cnt_q + K_WIDTH'(1);
                        if (cnt_q == k_q - K_WIDTH'(1)) begin
                            state_q <= S_FLUSH;
                            fcnt_q  <= '0;
                            ready_q <= 1'b0;
                        end
                    end
                end
                // Long enough for the last beat to reach the far corner PE.
                S_FLUSH: begin
                    if (fcnt_q == C_FLUSH_LAST) begin
                        state_q <= S_DRAIN;
                        row_q   <= '0;
                        valid_q <= 1'b1;
                    end else begin
                        fcnt_q  <= fcnt_q + C_FW'(1);
                    end
                end
                S_DRAIN: begin
                    if (out_ready_i) begin
                        if (row_q == C_ROW_LAST) begin
                            state_q <= S_IDLE;
                            row_q   <= '0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            row_q   <= row_q + C_RW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Row r of A is delayed r cycles before entering column 0.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_direct
            assign w_a_in[r][0]  = a_i[r*DATA_WIDTH +: DATA_WIDTH];
            assign w_av_in[r][0] = w_beat;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] a_sk_q  [r];
            logic                  av_sk_q [r];
            always_ff @(posedge clk) begin
                if (w_clr) begin
                    for (int i = 0; i < r; i++) begin
                        a_sk_q[i]  <= '0;
                        av_sk_q[i] <= 1'b0;
                    end
                end else begin
                    a_sk_q[0]  <= a_i[r*DATA_WIDTH +: DATA_WIDTH];
                    av_sk_q[0] <= w_beat;
                    for (int i = 1; i < r; i++) begin
                        a_sk_q[i]  <= a_sk_q[i-1];
                        av_sk_q[i] <= av_sk_q[i-1];
                    end
                end
            end
            assign w_a_in[r][0]  = a_sk_q[r-1];
            assign w_av_in[r][0] = av_sk_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_direct
            assign w_b_in[0][c]  = b_i[c*DATA_WIDTH +: DATA_WIDTH];
            assign w_bv_in[0][c] = w_beat;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] b_sk_q  [c];
            logic                  bv_sk_q [c];
            always_ff @(posedge clk) begin
                if (w_clr) begin
                    for (int i = 0; i < c; i++) begin
                        b_sk_q[i]  <= '0;
                        bv_sk_q[i] <= 1'b0;
                    end
                end else begin
                    b_sk_q[0]  <= b_i[c*DATA_WIDTH +: DATA_WIDTH];
                    bv_sk_q[0] <= w_beat;
                    for (int i = 1; i < c; i++) begin
                        b_sk_q[i]  <= b_sk_q[i-1];
                        bv_sk_q[i] <= bv_sk_q[i-1];
                    end
                end
            end
            assign w_b_in[0][c]  = b_sk_q[c-1];
            assign w_bv_in[0][c] = bv_sk_q[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic signed [ACC_WIDTH-1:0]    acc_q;
            logic signed [ACC_WIDTH-1:0]    acc_d;
            logic signed [2*DATA_WIDTH-1:0] w_prod;

            if (c > 0) begin : g_a_hop
                logic [DATA_WIDTH-1:0] a_q;
                logic                  av_q;
                always_ff @(posedge clk) begin
                    if (w_clr) begin
                        a_q  <= '0;
                        av_q <= 1'b0;
                    end else begin
                        a_q  <= w_a_in[r][c-1];
                        av_q <= w_av_in[r][c-1];
                    end
                end
                assign w_a_in[r][c]  = a_q;
                assign w_av_in[r][c] = av_q;
            end

            if (r > 0) begin : g_b_hop
                logic [DATA_WIDTH-1:0] b_q;
                logic                  bv_q;
                always_ff @(posedge clk) begin
                    if (w_clr) begin
                        b_q  <= '0;
                        bv_q <= 1'b0;
                    end else begin
                        b_q  <= w_b_in[r-1][c];
                        bv_q <= w_bv_in[r-1][c];
                    end
                end
                assign w_b_in[r][c]  = b_q;
                assign w_bv_in[r][c] = bv_q;
            end

            assign w_prod = $signed(w_a_in[r][c]) * $signed(w_b_in[r][c]);
            assign acc_d  = acc_q + ACC_WIDTH'(w_prod);

            always_ff @(posedge clk) begin
                if (w_clr) begin
                    acc_q <= '0;
                end else if (w_av_in[r][c] && w_bv_in[r][c]) begin
                    acc_q <= acc_d;
                end
            end

            assign w_sat[r][c] = (acc_q > C_MAX) ? C_MAX[OUT_WIDTH-1:0] :
                                 (acc_q < C_MIN) ? C_MIN[OUT_WIDTH-1:0] :
                                                   acc_q[OUT_WIDTH-1:0];
        end
    end

    always_comb begin
        out_data_o = '0;
        for (int c = 0; c < COLS; c++) begin
            if (valid_q) begin
                out_data_o[c*OUT_WIDTH +: OUT_WIDTH] = w_sat[row_q][c];
            end
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_row_o   = row_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_os_array.sv
`default_nettype none
// =====================================================================
// tb_systolic_os_array : directed checks of a 2x2 systolic_os_array.
// Rev 1.0
// =====================================================================
module tb_systolic_os_array;

    localparam int DW = 16;
    localparam int OW = 16;
    localparam int KW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start_i;
    logic [KW-1:0]   k_len_i;
    logic            clear_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [2*DW-1:0] a_i;
    logic [2*DW-1:0] b_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [0:0]      out_row_o;
    logic [2*OW-1:0] out_data_o;
    logic            busy_o;
    logic            done_o;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    systolic_os_array #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (40),
        .OUT_WIDTH  (OW),
        .ROWS       (2),
        .COLS       (2),
        .K_WIDTH    (KW)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .k_len_i     (k_len_i),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_row_o   (out_row_o),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_row(input string tag, input int row, input int d0, input int d1);
        logic [15:0] e0;
        logic [15:0] e1;
        e0 = d0[15:0];
        e1 = d1[15:0];
        check({tag, "_valid"}, out_valid_o, 1);
        check({tag, "_row"}, out_row_o, row);
        check({tag, "_c0"}, out_data_o[15:0], e0);
        check({tag, "_c1"}, out_data_o[31:16], e1);
    endtask

    task automatic start_job(input int k);
        start_i = 1'b1;
        k_len_i = k[KW-1:0];
        tick();
        start_i = 1'b0;
        k_len_i = '0;
    endtask

    task automatic beat(input logic v, input int a0, input int a1, input int b0, input int b1);
        in_valid_i = v;
        a_i = {16'(a1), 16'(a0)};
        b_i = {16'(b1), 16'(b0)};
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic wait_drain(output int cnt);
        cnt = 0;
        while (!out_valid_o && cnt < 50) begin
            tick();
            cnt++;
        end
    endtask

    task automatic drain_two(input string tag, input int r00, input int r01,
                             input int r10, input int r11);
        out_ready_i = 1'b1;
        check_row({tag, "_r0"}, 0, r00, r01);
        tick();
        check_row({tag, "_r1"}, 1, r10, r11);
        check({tag, "_done_low_r1"}, done_o, 0);
        tick();
        check({tag, "_done"}, done_o, 1);
        check({tag, "_valid_off"}, out_valid_o, 0);
        tick();
        check({tag, "_done_once"}, done_o, 0);
        check({tag, "_idle"}, busy_o, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        k_len_i     = '0;
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        a_i         = '0;
        b_i         = '0;
        tick();
        tick();
        check("rst_ready", in_ready_o, 0);
        check("rst_valid", out_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_row", out_row_o, 0);
        check("rst_data", out_data_o, 0);
        rst_n = 1'b1;
        tick();

        // Back-to-back 2x2 product
        start_job(2);
        check("t1_busy", busy_o, 1);
        check("t1_ready", in_ready_o, 1);
        beat(1'b1, 1, 3, 5, 6);
        beat(1'b1, 2, 4, 7, 8);
        check("t1_flush_ready", in_ready_o, 0);
        wait_drain(n);
        check("t1_flush_len", n, 3);
        drain_two("t1", 19, 22, 43, 50);

        // Bubbles between beats carry junk that must not accumulate
        start_job(2);
        beat(1'b1, 1, 3, 5, 6);
        beat(1'b0, 99, 99, 99, 99);
        beat(1'b0, 99, 99, 99, 99);
        check("t2_still_stream", in_ready_o, 1);
        beat(1'b1, 2, 4, 7, 8);
        check("t2_flush_ready", in_ready_o, 0);
        wait_drain(n);
        check("t2_flush_len", n, 3);
        drain_two("t2", 19, 22, 43, 50);

        // Positive and negative saturation
        start_job(2);
        beat(1'b1, 32767, 32767, 32767, 32767);
        beat(1'b1, 32767, 32767, 32767, 32767);
        wait_drain(n);
        check("t3p_flush_len", n, 3);
        drain_two("t3p", 32767, 32767, 32767, 32767);

        start_job(2);
        beat(1'b1, -32768, -32768, 32767, 32767);
        beat(1'b1, -32768, -32768, 32767, 32767);
        wait_drain(n);
        check("t3n_flush_len", n, 3);
        drain_two("t3n", -32768, -32768, -32768, -32768);

        // Backpressure holds row 0 stable
        out_ready_i = 1'b0;
        start_job(2);
        beat(1'b1, 1, 3, 5, 6);
        beat(1'b1, 2, 4, 7, 8);
        wait_drain(n);
        check("t4_flush_len", n, 3);
        for (int i = 0; i < 5; i++) begin
            check_row("t4_hold", 0, 19, 22);
            check("t4_hold_done", done_o, 0);
            tick();
        end
        drain_two("t4", 19, 22, 43, 50);

        // Abort after one beat, then a fresh K=1 job
        start_job(2);
        beat(1'b1, 100, 100, 100, 100);
        clear_i = 1'b1;
        start_i = 1'b1;
        k_len_i = 16'd3;
        tick();
        clear_i = 1'b0;
        start_i = 1'b0;
        k_len_i = '0;
        check("t5_abort_busy", busy_o, 0);
        check("t5_abort_ready", in_ready_o, 0);
        check("t5_abort_done", done_o, 0);
        start_job(1);
        beat(1'b1, 2, 3, 4, 5);
        wait_drain(n);
        check("t5_flush_len", n, 3);
        drain_two("t5", 8, 10, 12, 15);

        // Zero-length job
        start_job(0);
        check("t6_done", done_o, 1);
        check("t6_busy", busy_o, 0);
        check("t6_valid", out_valid_o, 0);
        tick();
        check("t6_done_once", done_o, 0);
        check("t6_valid_after", out_valid_o, 0);

        // Reset in DRAIN
        out_ready_i = 1'b0;
        start_job(1);
        beat(1'b1, 1, 1, 1, 1);
        wait_drain(n);
        check("t7_in_drain", out_valid_o, 1);
        rst_n = 1'b0;
        tick();
        check("t7_valid", out_valid_o, 0);
        check("t7_data", out_data_o, 0);
        check("t7_row", out_row_o, 0);
        check("t7_busy", busy_o, 0);
        check("t7_ready", in_ready_o, 0);
        check("t7_done", done_o, 0);
        rst_n = 1'b1;
        tick();
        check("t7_no_done", done_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
